// File: rtl/flit_injector.sv
// flit_injector: source-side network interface for the symmetric butterfly.
// Buffers a whole packet (descriptor + payload beats) and then emits it
// back-to-back on a 4-bit flit channel: header, payload flits, null gap.
// Optional build macro FLIT_INJECTOR_PKT_CNT_EN adds a 16-bit count of
// fully transmitted packets on output pkt_cnt.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high; ready is decoded from registered state only, never from valid.
module flit_injector #(
    parameter int PORTS      = 4,
    parameter int MAX_LEN    = 8,
    parameter int GAP_CYCLES = 1,
    localparam int ADDR_W    = $clog2(PORTS),
    localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [ADDR_W-1:0] pkt_dst,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              dat_valid,
    output logic              dat_ready,
    input  logic [1:0]        dat,
    output logic [3:0]        out_ch_hdr_msn,
    output logic              busy
`ifdef FLIT_INJECTOR_PKT_CNT_EN
    ,
    output logic [15:0]       pkt_cnt
`endif
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HEAD = 3'd2;
    localparam logic [2:0] S_BODY = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]        state;
    logic [IDX_W-1:0]  cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        data_buf [MAX_LEN];

    logic [LEN_W-1:0]  len_clamped;
    logic [IDX_W-1:0]  last_idx;
    logic              gap_done;

    // Oversized descriptors are trimmed to the buffer depth.
    assign len_clamped = (pkt_len > LEN_MAX) ? LEN_MAX : pkt_len;
    // Index of the final payload beat; only meaningful while len_q > 0.
    assign last_idx    = IDX_W'(len_q - LEN_W'(1));
    assign gap_done    = (state == S_GAP) && (gap_cnt == GAP_LAST);

    // Main sequencer: collect the packet, then stream it without stalling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            dst_q   <= '0;
            len_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pkt_valid) begin
                        dst_q <= pkt_dst;
                        len_q <= len_clamped;
                        cnt   <= '0;
                        state <= (len_clamped == '0) ? S_HEAD : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (dat_valid) begin
                        cnt <= cnt + IDX_W'(1);
                        if (cnt == last_idx) state <= S_HEAD;
                    end
                end
                S_HEAD: begin
                    cnt     <= '0;
                    gap_cnt <= '0;
                    state   <= (len_q != '0) ? S_BODY : S_GAP;
                end
                S_BODY: begin
                    if (cnt == last_idx) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_done) state <= S_IDLE;
                    else          gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Payload store; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && dat_valid) data_buf[cnt] <= dat;
    end

    // Output decode from registered state, buffer and counters only.
    always_comb begin
        out_ch_hdr_msn = 4'b0000;
        case (state)
            S_HEAD:  out_ch_hdr_msn = {2'b11, dst_q};
            S_BODY:  out_ch_hdr_msn = {2'b10, data_buf[cnt]};
            default: out_ch_hdr_msn = 4'b0000;
        endcase
    end

    assign pkt_ready = (state == S_IDLE);
    assign dat_ready = (state == S_LOAD);
    assign busy      = (state != S_IDLE);

`ifdef FLIT_INJECTOR_PKT_CNT_EN
    // Count packets that reached the end of their gap; aborted ones never do.
    always_ff @(posedge clk) begin
        if (rst)           pkt_cnt <= 16'h0000;
        else if (gap_done) pkt_cnt <= pkt_cnt + 16'h0001;
    end
`endif

endmodule
